ws2812_tx: RTL and testbench

//  Serialises a full LED frame into the single-wire WS2812 NRZ protocol.

---
 rtl/ws2812_pkg.sv | 13 +
 rtl/ws2812_bit_enc.sv | 30 +++
 rtl/ws2812_tx.sv | 131 +++++++++++++
 tb/tb_ws2812_tx.sv | 108 ++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// ws2812_pkg: state encoding, LED word width and 100MHz default timing shared by the WS2812 transmitter.
package ws2812_pkg;
    localparam int BIT_W       = 24;
    localparam int DEF_NUM_LED = 8;
    localparam int DEF_T0H_CYC = 40;
    localparam int DEF_T1H_CYC = 80;
    localparam int DEF_BIT_CYC = 125;
    localparam int DEF_RST_CYC = 30000;
    typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;
    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/ws2812_bit_enc.sv
// ws2812_bit_enc: one NRZ bit period per bit_go; a go on the bit_end cycle chains the next bit seamlessly.
module ws2812_bit_enc
    import ws2812_pkg::*;
#(
    parameter int T0H_CYC = DEF_T0H_CYC,
    parameter int T1H_CYC = DEF_T1H_CYC,
    parameter int BIT_CYC = DEF_BIT_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic bit_go,
    input  logic bit_val,
    output logic bit_end,
    output logic dout
);
    localparam int CW = $clog2(BIT_CYC);
    logic          active;
    logic [CW-1:0] cyc;
    assign bit_end = active && cyc == CW'(BIT_CYC - 1);
    assign dout    = active && cyc < (bit_val ? CW'(T1H_CYC) : CW'(T0H_CYC));
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active <= 1'b0;
            cyc    <= '0;
        end else begin
            active <= bit_go || (active && !bit_end);
            cyc    <= (bit_go || bit_end) ? '0 : active ? cyc + 1'b1 : cyc;
        end
    end
endmodule

// File: rtl/ws2812_tx.sv
// ws2812_tx: captures a GRB frame on start, shifts it out as WS2812 NRZ, then holds the latch interval.
// Define WS2812_PENDING_EN to queue one start received while busy and chain it after the latch.
module ws2812_tx
    import ws2812_pkg::*;
#(
    parameter int NUM_LED = DEF_NUM_LED,
    parameter int T0H_CYC = DEF_T0H_CYC,
    parameter int T1H_CYC = DEF_T1H_CYC,
    parameter int BIT_CYC = DEF_BIT_CYC,
    parameter int RST_CYC = DEF_RST_CYC
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [NUM_LED*BIT_W-1:0] rgb_data,
    output logic                     dout,
    output logic                     busy,
    output logic                     done
);
    localparam int FW    = NUM_LED * BIT_W;
    localparam int FW_W  = $clog2(FW);
    localparam int LED_W = NUM_LED > 1 ? $clog2(NUM_LED) : 1;
    localparam int BI_W  = $clog2(BIT_W);
    localparam int CYC_W = $clog2(max2(BIT_CYC, RST_CYC));
    localparam logic [BI_W-1:0] TOP_BIT = BI_W'(BIT_W - 1);

    if (!(T0H_CYC > 0 && T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC)) begin : g_bad_timing
        $error("ws2812_tx: timing must satisfy 0 < T0H_CYC < T1H_CYC < BIT_CYC");
    end

    state_t             state, state_n;
    logic [FW-1:0]      shadow, shadow_n;
    logic [LED_W-1:0]   led_idx, led_n;
    logic [BI_W-1:0]    bit_idx, bit_n;
    logic [CYC_W-1:0]   lat_cyc, lat_n;
    logic [FW_W-1:0]    bit_pos;
    logic               go, bit_end, cur_bit, last_bit;
`ifdef WS2812_PENDING_EN
    logic               pending, pend_n;
`endif

    assign bit_pos  = FW_W'(led_idx) * FW_W'(BIT_W) + FW_W'(bit_idx);
    assign cur_bit  = shadow[bit_pos];
    assign last_bit = led_idx == LED_W'(NUM_LED - 1) && bit_idx == '0;
    assign busy     = state != IDLE;

    ws2812_bit_enc #(
        .T0H_CYC(T0H_CYC),
        .T1H_CYC(T1H_CYC),
        .BIT_CYC(BIT_CYC)
    ) u_enc (
        .clk    (clk),
        .reset  (reset),
        .bit_go (go),
        .bit_val(cur_bit),
        .bit_end(bit_end),
        .dout   (dout)
    );

    always_comb begin
        state_n  = state;
        shadow_n = shadow;
        led_n    = led_idx;
        bit_n    = bit_idx;
        lat_n    = lat_cyc;
        go       = 1'b0;
        done     = 1'b0;
`ifdef WS2812_PENDING_EN
        pend_n   = pending || (start && state != IDLE);
`endif
        case (state)
            IDLE: if (start) begin
                state_n  = SEND;
                shadow_n = rgb_data;
                led_n    = '0;
                bit_n    = TOP_BIT;
                go       = 1'b1;
            end
            SEND: if (bit_end) begin
                if (last_bit) begin
                    state_n = LATCH;
                    lat_n   = '0;
                end else begin
                    go    = 1'b1;
                    bit_n = bit_idx == '0 ? TOP_BIT : bit_idx - 1'b1;
                    led_n = bit_idx == '0 ? led_idx + 1'b1 : led_idx;
                end
            end
            LATCH: if (lat_cyc == CYC_W'(RST_CYC - 1)) begin
                done    = 1'b1;
                state_n = IDLE;
`ifdef WS2812_PENDING_EN
                // a start landing on this very cycle counts as pending too
                if (pending || start) begin
                    state_n  = SEND;
                    shadow_n = rgb_data;
                    led_n    = '0;
                    bit_n    = TOP_BIT;
                    go       = 1'b1;
                    pend_n   = 1'b0;
                end
`endif
            end else begin
                lat_n = lat_cyc + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shadow  <= '0;
            led_idx <= '0;
            bit_idx <= '0;
            lat_cyc <= '0;
`ifdef WS2812_PENDING_EN
            pending <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            shadow  <= shadow_n;
            led_idx <= led_n;
            bit_idx <= bit_n;
            lat_cyc <= lat_n;
`ifdef WS2812_PENDING_EN
            pending <= pend_n;
`endif
        end
    end
endmodule

// File: tb/tb_ws2812_tx.sv
// tb_ws2812_tx: cycle-accurate scoreboard of {dout,busy,done} against a frame model built from the captured data.
module tb_ws2812_tx;
    localparam int NL = 2, T0H = 2, T1H = 4, BC = 6, RC = 10;
    localparam int FRAME = NL * 24 * BC + RC;
`ifdef WS2812_PENDING_EN
    localparam bit PEND = 1'b1;
`else
    localparam bit PEND = 1'b0;
`endif
    typedef struct packed {logic dout; logic busy; logic done;} exp_t;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [47:0] rgb_data = '0;
    logic        dout, busy, done;
    int          checks = 0, failures = 0;
    exp_t        q[$];

    ws2812_tx #(
        .NUM_LED(NL), .T0H_CYC(T0H), .T1H_CYC(T1H), .BIT_CYC(BC), .RST_CYC(RC)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .rgb_data(rgb_data),
        .dout(dout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [47:0] f);
        for (int i = 0; i < NL; i++)
            for (int b = 23; b >= 0; b--)
                for (int c = 0; c < BC; c++)
                    q.push_back('{dout: (c < (f[i*24+b] ? T1H : T0H)), busy: 1'b1, done: 1'b0});
        for (int c = 0; c < RC; c++)
            q.push_back('{dout: 1'b0, busy: 1'b1, done: (c == RC - 1)});
    endtask

    // called at a negedge; returns at the negedge of the first cycle after the last done
    task automatic run_frame(input logic [47:0] f, input int chg_at, input logic [47:0] f2,
                             input int start_at, input int tag);
        int   k = 0, t_done = -1;
        bit   pend = 1'b0;
        exp_t e;
        rgb_data = f;
        start    = 1'b1;
        push_frame(f);
        @(negedge clk);
        start = 1'b0;
        while (q.size() > 0) begin
            e = q.pop_front();
            chk($sformatf("f%0d cyc%0d {dout,busy,done}", tag, k), 32'({dout, busy, done}), 32'(e));
            if (done === 1'b1 && t_done < 0) t_done = k + 1;
            start = (k == start_at);
            if (k == start_at) pend = 1'b1;
            if (k == chg_at) rgb_data = f2;
            if (PEND && e.done && pend) begin
                push_frame(rgb_data);
                pend = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk($sformatf("f%0d start-to-done cycles", tag), t_done, FRAME);
        chk($sformatf("f%0d idle after done", tag), 32'({dout, busy, done}), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset dout", 32'(dout), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("idle no start %0d", i), 32'({dout, busy, done}), 0);
        end
        run_frame(48'h000001_800000, -1, '0, -1, 2);
        run_frame(48'hA5C30F_3C5A96, 30, 48'h5A3CF0_C3A569, -1, 3);
        run_frame(48'h123456_ABCDEF, -1, '0, 50, 4);
        rgb_data = 48'h000000_800000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre-reset dout high mid-bit", 32'(dout), 1);
        reset = 1'b1;
        #1;
        chk("async reset dout", 32'(dout), 0);
        chk("async reset busy", 32'(busy), 0);
        chk("async reset done", 32'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("after reset idle", 32'({dout, busy, done}), 0);
        run_frame({16'($urandom), 32'($urandom)}, -1, '0, -1, 5);
        run_frame(48'hFFFFFF_000000, -1, '0, -1, 6);
        run_frame(48'h00FF00_FF00FF, -1, '0, -1, 7);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
